// File: rtl/axis_packet_master.sv
// axis_packet_master: buffers locally written words in a FIFO and transmits them as fixed-length AXI4-Stream packets
module axis_packet_master #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_M_START_COUNT      = 32,
    parameter int PACKET_LEN           = 8,
    parameter int FIFO_DEPTH           = 16
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic                              wr_en,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   wr_data,
    output logic                              wr_full,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic                              overflow,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
    output logic                              packet_done
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int SW   = $clog2(PACKET_LEN);
    localparam int CW   = (C_M_START_COUNT > 1) ? $clog2(C_M_START_COUNT) : 1;
    localparam int PLM1 = PACKET_LEN - 1;
    localparam int SCM1 = C_M_START_COUNT - 1;
    localparam logic [AW:0]   PKT        = PACKET_LEN[AW:0];
    localparam logic [AW:0]   DEPTH      = FIFO_DEPTH[AW:0];
    localparam logic [SW-1:0] LAST_SENT  = PLM1[SW-1:0];
    localparam logic [CW-1:0] START_LAST = SCM1[CW-1:0];

    typedef enum logic [1:0] {INIT_COUNTER, IDLE, SEND_STREAM} state_t;

    state_t                          state, state_nxt;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]                   wr_ptr, rd_ptr;
    logic [CW-1:0]                   start_cnt;
    logic [SW-1:0]                   sent;
    logic                            push, pop;

    assign push          = wr_en && !wr_full;
    assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;
    assign wr_full       = fifo_count == DEPTH;
    assign M_AXIS_TVALID = state == SEND_STREAM;
    assign M_AXIS_TLAST  = M_AXIS_TVALID && sent == LAST_SENT;
    assign M_AXIS_TDATA  = mem[rd_ptr];
    assign M_AXIS_TSTRB  = '1;

    // FIFO storage: no reset needed, contents are only read behind a valid count
    always_ff @(posedge M_AXIS_ACLK) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // FIFO pointers, occupancy and the sticky drop flag
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (wr_en && wr_full) overflow <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) state <= INIT_COUNTER;
        else state <= state_nxt;
    end

    // Next state: start-up delay, wait for a whole packet, then stream it out
    always_comb begin
        state_nxt = state;
        if (state == INIT_COUNTER && start_cnt == START_LAST) state_nxt = IDLE;
        else if (state == IDLE && fifo_count >= PKT) state_nxt = SEND_STREAM;
        else if (state == SEND_STREAM && pop && M_AXIS_TLAST) state_nxt = IDLE;
    end

    // Start-up and sent-word counters plus the end-of-packet pulse
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            start_cnt   <= '0;
            sent        <= '0;
            packet_done <= 1'b0;
        end else begin
            if (state == INIT_COUNTER) start_cnt <= start_cnt + 1'b1;
            sent        <= (state != SEND_STREAM) ? '0 : pop ? (M_AXIS_TLAST ? '0 : sent + 1'b1) : sent;
            packet_done <= pop && M_AXIS_TLAST;
        end
    end
endmodule

// File: tb/tb_axis_packet_master.sv
// tb_axis_packet_master: randomized and directed checks of axis_packet_master against a queue-based model
module tb_axis_packet_master;
    localparam int W  = 32;
    localparam int SC = 32;
    localparam int PL = 8;
    localparam int D  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           wr_en = 1'b0;
    logic           tready = 1'b0;
    logic [W-1:0]   wr_data = '0;
    logic           wr_full, overflow, tvalid, tlast, packet_done;
    logic [4:0]     fifo_count;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tstrb;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] out_log[$];
    logic [W-1:0] in_log[$];
    bit           last_log[$];
    int           hs_e[$];
    int           e, m_sent, m_first, dut_first, dones;
    bit           m_valid, m_done, m_ovf, prev_stall;
    logic [W-1:0] prev_data;
    logic         prev_last;

    axis_packet_master #(
        .C_M_AXIS_TDATA_WIDTH(W),
        .C_M_START_COUNT(SC),
        .PACKET_LEN(PL),
        .FIFO_DEPTH(D)
    ) dut (
        .M_AXIS_ACLK(clk),
        .M_AXIS_ARESETN(rst_n),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wr_full(wr_full),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TDATA(tdata),
        .M_AXIS_TSTRB(tstrb),
        .M_AXIS_TLAST(tlast),
        .M_AXIS_TREADY(tready),
        .packet_done(packet_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        out_log.delete();
        last_log.delete();
        hs_e.delete();
        in_log.delete();
        dones = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        e = 0;
        m_valid = 0;
        m_sent = 0;
        m_done = 0;
        m_ovf = 0;
        prev_stall = 0;
        m_first = -1;
        dut_first = -1;
    endtask

    // Packet rules: words leave in push order, a packet starts only with PL words stored,
    // never before edge SC+1 after reset, and never on the edge right after a packet ends
    task automatic model_step();
        int sz;
        bit last, push, pop;
        sz   = mq.size();
        last = m_valid && m_sent == PL - 1;
        push = wr_en && sz < D;
        pop  = m_valid && tready;
        if (wr_en && sz == D) m_ovf = 1;
        m_done = pop && last;
        if (pop) mq.delete(0);
        if (push) mq.push_back(wr_data);
        e++;
        if (m_valid && pop) begin
            if (last) begin
                m_valid = 0;
                m_sent = 0;
            end else m_sent++;
        end else if (!m_valid && e >= SC + 1 && sz >= PL) begin
            m_valid = 1;
            if (m_first < 0) m_first = e;
        end
    endtask

    task automatic compare();
        chk("tvalid", 64'(tvalid), 64'(m_valid));
        chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
        chk("wr_full", 64'(wr_full), 64'(mq.size() == D));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("packet_done", 64'(packet_done), 64'(m_done));
        chk("tlast", 64'(tlast), 64'(m_valid && m_sent == PL - 1));
        if (m_valid && mq.size() > 0) chk("tdata", 64'(tdata), 64'(mq[0]));
        if (prev_stall) begin
            chk("hold_valid", 64'(tvalid), 64'(1));
            chk("hold_data", 64'(tdata), 64'(prev_data));
            chk("hold_last", 64'(tlast), 64'(prev_last));
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
        if (tvalid && tready) begin
            out_log.push_back(tdata);
            last_log.push_back(tlast);
            hs_e.push_back(e);
        end
        if (tvalid && dut_first < 0) dut_first = e;
        if (packet_done) dones++;
    endtask

    // Model advances on each rising edge; outputs are compared on the falling edge
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            @(negedge clk);
            if (rst_n) compare();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        tick();
        tick();
        clear_logs();
        rst_n = 1'b1;
    endtask

    initial begin
        int n, lim;
        // T1: start-up delay then the first packet
        tready = 1'b1;
        do_reset();
        chk("rst_tvalid", 64'(tvalid), 64'(0));
        chk("rst_count", 64'(fifo_count), 64'(0));
        chk("rst_full", 64'(wr_full), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("tstrb", 64'(tstrb), 64'(4'hF));
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_data = W'(i);
            tick();
        end
        wr_en = 1'b0;
        repeat (40) tick();
        chk("t1_model_first", 64'(m_first), 64'(33));
        chk("t1_dut_first", 64'(dut_first), 64'(33));
        chk("t1_words", 64'(out_log.size()), 64'(8));
        if (out_log.size() == 8)
            for (int i = 0; i < 8; i++) begin
                chk("t1_data", 64'(out_log[i]), 64'(i));
                chk("t1_last", 64'(last_log[i]), 64'(i == 7));
            end
        chk("t1_dones", 64'(dones), 64'(1));

        // T2: continuous pushes, two packets one IDLE cycle apart
        clear_logs();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_data = W'(32'h100 + i);
            tick();
        end
        wr_en = 1'b0;
        repeat (30) tick();
        chk("t2_words", 64'(out_log.size()), 64'(16));
        if (out_log.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("t2_data", 64'(out_log[i]), 64'(32'h100 + i));
            chk("t2_gap", 64'(hs_e[8] - hs_e[7]), 64'(2));
            chk("t2_contig", 64'(hs_e[7] - hs_e[0]), 64'(7));
        end
        chk("t2_count", 64'(fifo_count), 64'(0));
        chk("t2_dones", 64'(dones), 64'(2));

        // T3: back-pressure pattern 1,0,0,1,0,0,...
        clear_logs();
        for (int c = 0; c < 60; c++) begin
            tready = (c % 3 == 0);
            wr_en = (c < 8);
            wr_data = W'(32'h200 + c);
            tick();
        end
        wr_en = 1'b0;
        tready = 1'b1;
        tick();
        chk("t3_words", 64'(out_log.size()), 64'(8));
        if (out_log.size() == 8)
            for (int i = 0; i < 8; i++) begin
                chk("t3_data", 64'(out_log[i]), 64'(32'h200 + i));
                chk("t3_last", 64'(last_log[i]), 64'(i == 7));
            end

        // T4: full FIFO, refused push during a pop, push+pop at count 10
        clear_logs();
        tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_data = W'(32'h300 + i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        chk("t4_count16", 64'(fifo_count), 64'(16));
        chk("t4_full", 64'(wr_full), 64'(1));
        chk("t4_valid", 64'(tvalid), 64'(1));
        tready = 1'b1;
        wr_en = 1'b1;
        wr_data = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        tready = 1'b0;
        chk("t4_count15", 64'(fifo_count), 64'(15));
        chk("t4_ovf", 64'(overflow), 64'(1));
        tready = 1'b1;
        repeat (5) tick();
        chk("t4_count10", 64'(fifo_count), 64'(10));
        wr_en = 1'b1;
        wr_data = 32'h400;
        tick();
        wr_en = 1'b0;
        chk("t4_pushpop", 64'(fifo_count), 64'(10));
        repeat (40) tick();
        chk("t4_words", 64'(out_log.size()), 64'(16));
        if (out_log.size() == 16)
            for (int i = 0; i < 16; i++) chk("t4_data", 64'(out_log[i]), 64'(32'h300 + i));
        chk("t4_left", 64'(fifo_count), 64'(1));

        // T5: pointer wrap with random bursts and random back-pressure
        do_reset();
        chk("t5_ovf_clr", 64'(overflow), 64'(0));
        n = 0;
        lim = 0;
        while (n < 40 && lim < 3000) begin
            tready = 1'($urandom_range(0, 1));
            if (!wr_full && $urandom_range(0, 2) != 0) begin
                wr_en = 1'b1;
                wr_data = $urandom;
                in_log.push_back(wr_data);
                n++;
            end else wr_en = 1'b0;
            tick();
            lim++;
        end
        chk("t5_pushed", 64'(n), 64'(40));
        wr_en = 1'b0;
        tready = 1'b1;
        repeat (60) tick();
        chk("t5_words", 64'(out_log.size()), 64'(in_log.size()));
        if (out_log.size() == in_log.size())
            for (int i = 0; i < out_log.size(); i++) begin
                chk("t5_data", 64'(out_log[i]), 64'(in_log[i]));
                chk("t5_last", 64'(last_log[i]), 64'(i % 8 == 7));
            end
        chk("t5_count", 64'(fifo_count), 64'(0));

        // T6: reset at word 3 of a packet, start-up delay re-run
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_data = W'(32'h600 + i);
            tick();
        end
        wr_en = 1'b0;
        lim = 0;
        while (out_log.size() < 3 && lim < 100) begin
            tick();
            lim++;
        end
        chk("t6_reached_w3", 64'(out_log.size()), 64'(3));
        rst_n = 1'b0;
        #1;
        chk("t6_valid_drop", 64'(tvalid), 64'(0));
        chk("t6_count_clr", 64'(fifo_count), 64'(0));
        chk("t6_last_clr", 64'(tlast), 64'(0));
        tick();
        tick();
        clear_logs();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_data = W'(32'h700 + i);
            tick();
        end
        wr_en = 1'b0;
        repeat (40) tick();
        chk("t6_model_first", 64'(m_first), 64'(33));
        chk("t6_dut_first", 64'(dut_first), 64'(33));
        chk("t6_words", 64'(out_log.size()), 64'(8));
        if (out_log.size() == 8)
            for (int i = 0; i < 8; i++) chk("t6_data", 64'(out_log[i]), 64'(32'h700 + i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
